// File: rtl/mem_wb_stage.sv
// Memory-access stage with the MEM/WB pipeline register.
// The stage owns the data memory. A store commits at the clock edge in one cycle.
// A load holds the upstream EX/MEM register for RD_LAT cycles, then its result is captured.
module mem_wb_stage #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8,
    parameter int RD_LAT = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] alu_result_in,
    input  logic [DATA_W-1:0] write_data_in,
    input  logic [2:0]        rd_in,
    input  logic              mem_read_in,
    input  logic              mem_write_in,
    input  logic              reg_write_in,
    input  logic              mem_to_reg_in,
    output logic              stall_out,
    output logic [DATA_W-1:0] wb_data_out,
    output logic [2:0]        rd_out,
    output logic              reg_write_out
);

    // On entry to WAIT the counter is loaded with RD_LAT-1. It runs down to zero,
    // and the load result is captured in the zero cycle.
    localparam logic [2:0] LAT_M1   = (RD_LAT > 0) ? 3'(RD_LAT - 1) : 3'd0;
    localparam bit         HAS_WAIT = (RD_LAT != 0);

    typedef enum logic {IDLE, WAIT} state_t;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [2:0]        rd;
        logic              we;
    } wb_t;

    state_t            state, state_nxt;
    logic [2:0]        cnt, cnt_nxt;
    logic              capture;
    logic              stall;
    logic              is_load;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] mem_rdata;
    wb_t               wb_q, wb_nxt;

    logic [DATA_W-1:0] mem [2**ADDR_W];

    // The address wraps naturally because only the low ADDR_W bits are used.
    assign addr      = ADDR_W'(alu_result_in);
    assign mem_rdata = mem[addr];

    // When read and write are both set, the decode is treated as a store.
    assign is_load   = mem_read_in & ~mem_write_in;

    // Next-state logic. It also decides whether MEM/WB captures this cycle or takes a bubble.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        capture   = 1'b0;
        stall     = 1'b0;
        case (state)
            IDLE: begin
                if (is_load && HAS_WAIT) begin
                    state_nxt = WAIT;
                    cnt_nxt   = LAT_M1;
                    stall     = 1'b1;
                end else begin
                    capture   = 1'b1;
                end
            end
            WAIT: begin
                if (cnt != 3'd0) begin
                    cnt_nxt   = cnt - 3'd1;
                    stall     = 1'b1;
                end else begin
                    capture   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = 3'd0;
            end
        endcase
    end

    // A reset aborts any load in flight, so stall drops during the reset cycle.
    assign stall_out = stall & ~reset;

    // Write-back payload. A bubble is all zeros. When the stage captures, the payload
    // takes either the ALU result or the memory data. The memory data is never used
    // for a store.
    always_comb begin
        wb_nxt = '0;
        if (capture) begin
            wb_nxt.data = (mem_to_reg_in && !mem_write_in) ? mem_rdata : alu_result_in;
            wb_nxt.rd   = rd_in;
            wb_nxt.we   = reg_write_in;
        end
    end

    // FSM and MEM/WB register. Both are reset synchronously.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= 3'd0;
            wb_q  <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            wb_q  <= wb_nxt;
        end
    end

    // The data memory is never cleared. A store writes only in IDLE, because in WAIT
    // upstream is holding a load.
    always_ff @(posedge clk) begin
        if (!reset && state == IDLE && mem_write_in)
            mem[addr] <= write_data_in;
    end

    assign wb_data_out   = wb_q.data;
    assign rd_out        = wb_q.rd;
    assign reg_write_out = wb_q.we;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage. Three instances run with RD_LAT = 0, 2 and 3.
// Each instance has its own input set. The bench applies a table of directed vectors,
// hand sequences for reset, and random traffic checked against a memory model.
module tb_mem_wb_stage;

    localparam int LAT [3] = '{0, 2, 3};

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] alu_i [3];
    logic [7:0] wd_i  [3];
    logic [2:0] rd_i  [3];
    logic       mr_i  [3];
    logic       mw_i  [3];
    logic       rw_i  [3];
    logic       m2r_i [3];
    logic       stall_o [3];
    logic [7:0] wb_o  [3];
    logic [2:0] rd_o  [3];
    logic       rw_o  [3];

    int checks = 0;
    int failures = 0;

    // Reference memory, one per instance, with a flag for each location the bench has written.
    logic [7:0] mdl_mem [3][256];
    bit         mdl_ok  [3][256];

    always #5 clk = ~clk;

    mem_wb_stage #(.DATA_W(8), .ADDR_W(8), .RD_LAT(0)) dut0 (
        .clk(clk), .reset(reset), .alu_result_in(alu_i[0]), .write_data_in(wd_i[0]),
        .rd_in(rd_i[0]), .mem_read_in(mr_i[0]), .mem_write_in(mw_i[0]),
        .reg_write_in(rw_i[0]), .mem_to_reg_in(m2r_i[0]), .stall_out(stall_o[0]),
        .wb_data_out(wb_o[0]), .rd_out(rd_o[0]), .reg_write_out(rw_o[0]));

    mem_wb_stage #(.DATA_W(8), .ADDR_W(8), .RD_LAT(2)) dut2 (
        .clk(clk), .reset(reset), .alu_result_in(alu_i[1]), .write_data_in(wd_i[1]),
        .rd_in(rd_i[1]), .mem_read_in(mr_i[1]), .mem_write_in(mw_i[1]),
        .reg_write_in(rw_i[1]), .mem_to_reg_in(m2r_i[1]), .stall_out(stall_o[1]),
        .wb_data_out(wb_o[1]), .rd_out(rd_o[1]), .reg_write_out(rw_o[1]));

    mem_wb_stage #(.DATA_W(8), .ADDR_W(8), .RD_LAT(3)) dut3 (
        .clk(clk), .reset(reset), .alu_result_in(alu_i[2]), .write_data_in(wd_i[2]),
        .rd_in(rd_i[2]), .mem_read_in(mr_i[2]), .mem_write_in(mw_i[2]),
        .reg_write_in(rw_i[2]), .mem_to_reg_in(m2r_i[2]), .stall_out(stall_o[2]),
        .wb_data_out(wb_o[2]), .rd_out(rd_o[2]), .reg_write_out(rw_o[2]));

    typedef struct {
        int         d;
        logic [7:0] alu, wd;
        logic [2:0] rd;
        logic       mr, mw, rw, m2r;
        int         exp_stalls;
        logic [7:0] exp_data;
        logic [2:0] exp_rd;
        logic       exp_we;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs(input int d);
        alu_i[d] = '0; wd_i[d] = '0; rd_i[d] = '0;
        mr_i[d] = 0; mw_i[d] = 0; rw_i[d] = 0; m2r_i[d] = 0;
    endtask

    // Enter at posedge+1. The task holds the instruction while stall is high and checks
    // that bubbles are loaded. It returns the stall count and the captured outputs, and
    // leaves again at posedge+1.
    task automatic do_op(input int d, input logic [7:0] alu, input logic [7:0] wd,
                         input logic [2:0] rd, input logic mr, input logic mw,
                         input logic rw, input logic m2r, output int stalls,
                         output logic [7:0] o_data, output logic [2:0] o_rd,
                         output logic o_we);
        logic s;
        alu_i[d] = alu; wd_i[d] = wd; rd_i[d] = rd;
        mr_i[d] = mr; mw_i[d] = mw; rw_i[d] = rw; m2r_i[d] = m2r;
        stalls = 0;
        forever begin
            #1 s = stall_o[d];
            @(posedge clk);
            #1;
            if (!s) break;
            stalls++;
            chk("bubble_reg_write", int'(rw_o[d]), 0);
            if (stalls > 20) begin
                chk("stall_timeout", stalls, 0);
                break;
            end
        end
        o_data = wb_o[d]; o_rd = rd_o[d]; o_we = rw_o[d];
        idle_inputs(d);
    endtask

    // Reference model for one instruction. It works from the architectural rules only:
    // a load costs LAT stall cycles, write-back data is either the memory word or the
    // ALU value, and a store commits afterwards.
    task automatic model_op(input int d, input logic [7:0] alu, input logic [7:0] wd,
                            input logic mr, input logic mw, input logic m2r,
                            output int exp_stalls, output logic [7:0] exp_data,
                            output bit data_known);
        bit use_mem;
        use_mem    = m2r && !mw;
        exp_stalls = (mr && !mw) ? LAT[d] : 0;
        exp_data   = use_mem ? mdl_mem[d][alu] : alu;
        data_known = !use_mem || mdl_ok[d][alu];
        if (mw) begin
            mdl_mem[d][alu] = wd;
            mdl_ok[d][alu]  = 1'b1;
        end
    endtask

    initial begin
        vec_t       tbl [9];
        int         stalls, es;
        logic [7:0] od, ed;
        logic [2:0] ord;
        logic       owe;
        bit         known;

        for (int d = 0; d < 3; d++) begin
            idle_inputs(d);
            for (int a = 0; a < 256; a++) begin
                mdl_mem[d][a] = '0;
                mdl_ok[d][a]  = 1'b0;
            end
        end

        //          d  alu    wd     rd mr mw rw m2r stl data   rd we
        tbl[0] = '{1, 8'h3C, 8'h00, 5, 0, 0, 1, 0,  0, 8'h3C, 5, 1};
        tbl[1] = '{1, 8'h10, 8'hA5, 0, 0, 1, 0, 0,  0, 8'h10, 0, 0};
        tbl[2] = '{1, 8'h10, 8'h00, 3, 1, 0, 1, 1,  2, 8'hA5, 3, 1};
        tbl[3] = '{0, 8'hFF, 8'h7E, 0, 0, 1, 0, 0,  0, 8'hFF, 0, 0};
        tbl[4] = '{0, 8'hFF, 8'h00, 2, 1, 0, 1, 1,  0, 8'h7E, 2, 1};
        tbl[5] = '{1, 8'h20, 8'h55, 4, 1, 1, 1, 1,  0, 8'h20, 4, 1};
        tbl[6] = '{1, 8'h20, 8'h00, 6, 1, 0, 1, 1,  2, 8'h55, 6, 1};
        tbl[7] = '{2, 8'h05, 8'h33, 0, 0, 1, 0, 0,  0, 8'h05, 0, 0};
        tbl[8] = '{2, 8'h05, 8'h00, 7, 1, 0, 1, 1,  3, 8'h33, 7, 1};

        // Reset for two cycles while a load is presented. Stall must stay low.
        for (int d = 0; d < 3; d++) mr_i[d] = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(posedge clk);
            #1;
            for (int d = 0; d < 3; d++) chk("reset_stall", int'(stall_o[d]), 0);
        end
        for (int d = 0; d < 3; d++) begin
            chk("reset_wb_data", int'(wb_o[d]), 0);
            chk("reset_rd", int'(rd_o[d]), 0);
            chk("reset_reg_write", int'(rw_o[d]), 0);
            idle_inputs(d);
        end
        reset = 1'b0;

        // Directed vectors.
        foreach (tbl[i]) begin
            model_op(tbl[i].d, tbl[i].alu, tbl[i].wd, tbl[i].mr, tbl[i].mw, tbl[i].m2r,
                     es, ed, known);
            do_op(tbl[i].d, tbl[i].alu, tbl[i].wd, tbl[i].rd, tbl[i].mr, tbl[i].mw,
                  tbl[i].rw, tbl[i].m2r, stalls, od, ord, owe);
            chk($sformatf("vec%0d_stalls", i), stalls, tbl[i].exp_stalls);
            chk($sformatf("vec%0d_wb_data", i), int'(od), int'(tbl[i].exp_data));
            chk($sformatf("vec%0d_rd", i), int'(ord), int'(tbl[i].exp_rd));
            chk($sformatf("vec%0d_reg_write", i), int'(owe), int'(tbl[i].exp_we));
        end

        // Reset during the second stall cycle of a RD_LAT=3 load.
        alu_i[2] = 8'h05; rd_i[2] = 3'd7; mr_i[2] = 1; rw_i[2] = 1; m2r_i[2] = 1;
        #1 chk("midwait_stall_T", int'(stall_o[2]), 1);
        @(posedge clk);
        #1 chk("midwait_stall_T1", int'(stall_o[2]), 1);
        reset = 1'b1;
        #1 chk("midwait_stall_in_reset", int'(stall_o[2]), 0);
        @(posedge clk);
        #1;
        chk("midwait_wb_data", int'(wb_o[2]), 0);
        chk("midwait_rd", int'(rd_o[2]), 0);
        chk("midwait_reg_write", int'(rw_o[2]), 0);
        reset = 1'b0;
        do_op(2, 8'h05, 8'h00, 3'd7, 1, 0, 1, 1, stalls, od, ord, owe);
        chk("fresh_load_stalls", stalls, 3);
        chk("fresh_load_wb_data", int'(od), 8'h33);
        chk("fresh_load_rd", int'(ord), 7);

        // Random traffic on each instance. Addresses stay in a region the bench prefills.
        for (int d = 0; d < 3; d++) begin
            for (int a = 8'h40; a < 8'h50; a++) begin
                logic [7:0] v;
                v = 8'($urandom);
                model_op(d, 8'(a), v, 0, 1, 0, es, ed, known);
                do_op(d, 8'(a), v, 3'd0, 0, 1, 0, 0, stalls, od, ord, owe);
                chk("prefill_stalls", stalls, es);
            end
            for (int n = 0; n < 80; n++) begin
                logic [7:0] alu, wd;
                logic [2:0] rd;
                logic       mr, mw, rw, m2r;
                int         kind;
                kind = int'($urandom_range(0, 9));
                alu  = 8'h40 | 8'($urandom_range(0, 15));
                wd   = 8'($urandom);
                rd   = 3'($urandom);
                rw   = 1'($urandom);
                mr = 0; mw = 0; m2r = 0;
                if (kind < 3) begin
                    alu = 8'($urandom);
                end else if (kind < 6) begin
                    mw = 1; rw = 0;
                end else if (kind < 9) begin
                    mr = 1; m2r = 1'($urandom_range(0, 3) != 0);
                end else begin
                    mr = 1; mw = 1; m2r = 1;
                end
                model_op(d, alu, wd, mr, mw, m2r, es, ed, known);
                do_op(d, alu, wd, rd, mr, mw, rw, m2r, stalls, od, ord, owe);
                chk("rand_stalls", stalls, es);
                if (known) chk("rand_wb_data", int'(od), int'(ed));
                chk("rand_rd", int'(ord), int'(rd));
                chk("rand_reg_write", int'(owe), int'(rw));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
